// File: rtl/pito_pkg.sv
// ---------------------------------------------------------------------------
// pito_pkg
// Shared types and constants for the barrel core's MVU job dispatch path.
//   NUM_HARTS        number of barrel harts
//   HART_CNT_WIDTH   width of a hart index
//   mvu_job_t        88-bit snapshot of one hart's MVU configuration
//   mvu_disp_state_e dispatcher FSM states
// ---------------------------------------------------------------------------
package pito_pkg;

    localparam int NUM_HARTS      = 8;
    localparam int HART_CNT_WIDTH = $clog2(NUM_HARTS);

    localparam int MVU_MODE_W  = 2;
    localparam int MVU_CNT_W   = 29;
    localparam int MVU_PREC_W  = 6;
    localparam int MVU_WADDR_W = 9;
    localparam int MVU_DADDR_W = 15;

    // Field order fixes the packed layout seen on the mvu_job bus (MSB first).
    typedef struct packed {
        logic [MVU_MODE_W-1:0]  mul_mode;
        logic [MVU_CNT_W-1:0]   countdown;
        logic [MVU_PREC_W-1:0]  wprec;
        logic [MVU_PREC_W-1:0]  iprec;
        logic [MVU_PREC_W-1:0]  oprec;
        logic [MVU_WADDR_W-1:0] wbase;
        logic [MVU_DADDR_W-1:0] ibase;
        logic [MVU_DADDR_W-1:0] obase;
    } mvu_job_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } mvu_disp_state_e;

endpackage

// File: rtl/mvu_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mvu_rr_arbiter
// Combinational round-robin picker: returns the first set request at or after
// ptr_i, wrapping past the top index back to 0.
//   req_i    request vector
//   ptr_i    index with highest priority this cycle (must be < NUM_REQ)
//   grant_o  index of the selected request (0 when valid_o is low)
//   valid_o  at least one request is set
// ---------------------------------------------------------------------------
module mvu_rr_arbiter #(
    parameter int NUM_REQ = 8,
    parameter int IDX_W   = 3
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [IDX_W-1:0]   grant_o,
    output logic               valid_o
);

    int idx;

    // Scan from the lowest-priority offset down to offset 0 so the last hit
    // written is the one closest to ptr_i.
    always_comb begin
        grant_o = '0;
        valid_o = 1'b0;
        idx     = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = int'(ptr_i) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (req_i[idx]) begin
                grant_o = idx[IDX_W-1:0];
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mvu_job_dispatcher.sv
// ---------------------------------------------------------------------------
// mvu_job_dispatcher
// Snapshots each hart's MVU configuration when it pulses mvu_start, then
// arbitrates pending jobs round-robin onto the single MVU command port and
// returns a one-cycle mvu_irq to the owning hart on completion.
//
// Optional feature: define MVU_WATCHDOG_EN to add a RUN-state watchdog that
// aborts a job running longer than countdown + TIMEOUT_SLACK cycles and
// flags it through mvu_err. Without it mvu_abort/mvu_err are tied low.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   mvu_start               per-hart start pulse
//   csr_mvu_*               per-hart configuration slices from the CSR bank
//   mvu_cmd_valid/ready     command handshake towards the MVU
//   mvu_job, mvu_job_hart   registered job fields and owning hart
//   mvu_done                MVU completion pulse
//   mvu_abort               watchdog abort pulse to the MVU
//   mvu_irq, mvu_err        per-hart completion / error pulses
//   busy                    FSM not idle
// ---------------------------------------------------------------------------
module mvu_job_dispatcher #(
    parameter int NUM_HARTS     = pito_pkg::NUM_HARTS,
    parameter int TIMEOUT_SLACK = 64
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_HARTS-1:0]                mvu_start,
    input  logic [2*NUM_HARTS-1:0]              csr_mvu_mul_mode,
    input  logic [29*NUM_HARTS-1:0]             csr_mvu_countdown,
    input  logic [6*NUM_HARTS-1:0]              csr_mvu_wprecision,
    input  logic [6*NUM_HARTS-1:0]              csr_mvu_iprecision,
    input  logic [6*NUM_HARTS-1:0]              csr_mvu_oprecision,
    input  logic [9*NUM_HARTS-1:0]              csr_mvu_wbaseaddr,
    input  logic [15*NUM_HARTS-1:0]             csr_mvu_ibaseaddr,
    input  logic [15*NUM_HARTS-1:0]             csr_mvu_obaseaddr,
    output logic                                mvu_cmd_valid,
    input  logic                                mvu_cmd_ready,
    output pito_pkg::mvu_job_t                  mvu_job,
    output logic [pito_pkg::HART_CNT_WIDTH-1:0] mvu_job_hart,
    input  logic                                mvu_done,
    output logic                                mvu_abort,
    output logic [NUM_HARTS-1:0]                mvu_irq,
    output logic [NUM_HARTS-1:0]                mvu_err,
    output logic                                busy
);

    import pito_pkg::*;

    localparam logic [NUM_HARTS-1:0]      HART_ONE  = NUM_HARTS'(1);
    localparam logic [HART_CNT_WIDTH-1:0] LAST_HART = HART_CNT_WIDTH'(NUM_HARTS - 1);

    mvu_disp_state_e             state_q;
    logic [NUM_HARTS-1:0]        pending_q, pending_d;
    logic [NUM_HARTS-1:0]        start_acc;
    logic [NUM_HARTS-1:0]        grant_mask;
    logic [NUM_HARTS-1:0]        owner_mask;
    logic                        owner_active;
    mvu_job_t                    shadow_q [NUM_HARTS];
    logic [HART_CNT_WIDTH-1:0]   rr_ptr_q;
    logic [HART_CNT_WIDTH-1:0]   arb_grant;
    logic                        arb_valid;
    logic                        cmd_valid_q;
    mvu_job_t                    job_q;
    logic [HART_CNT_WIDTH-1:0]   job_hart_q;
    logic [NUM_HARTS-1:0]        irq_q;

    // The owning hart is locked out only while its job is on the MVU; in
    // DONE it may already queue its next job.
    assign owner_active = (state_q == ST_ISSUE) || (state_q == ST_RUN);
    assign owner_mask   = HART_ONE << job_hart_q;
    assign start_acc    = mvu_start & ~pending_q & ~(owner_active ? owner_mask : '0);
    assign grant_mask   = (arb_valid && (state_q == ST_IDLE)) ? (HART_ONE << arb_grant) : '0;
    assign pending_d    = (pending_q & ~grant_mask) | start_acc;

    // Per-hart snapshot of the CSR slices, captured on an accepted start.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_HARTS; gi++) begin : g_hart
            mvu_job_t snap;

            assign snap.mul_mode  = csr_mvu_mul_mode[gi*2 +: 2];
            assign snap.countdown = csr_mvu_countdown[gi*29 +: 29];
            assign snap.wprec     = csr_mvu_wprecision[gi*6 +: 6];
            assign snap.iprec     = csr_mvu_iprecision[gi*6 +: 6];
            assign snap.oprec     = csr_mvu_oprecision[gi*6 +: 6];
            assign snap.wbase     = csr_mvu_wbaseaddr[gi*9 +: 9];
            assign snap.ibase     = csr_mvu_ibaseaddr[gi*15 +: 15];
            assign snap.obase     = csr_mvu_obaseaddr[gi*15 +: 15];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    shadow_q[gi] <= '0;
                end else if (start_acc[gi]) begin
                    shadow_q[gi] <= snap;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    mvu_rr_arbiter #(
        .NUM_REQ (NUM_HARTS),
        .IDX_W   (HART_CNT_WIDTH)
    ) u_arb (
        .req_i   (pending_q),
        .ptr_i   (rr_ptr_q),
        .grant_o (arb_grant),
        .valid_o (arb_valid)
    );

`ifdef MVU_WATCHDOG_EN
    logic [29:0]          wd_cnt_q;
    logic [29:0]          wd_limit;
    logic                 abort_q;
    logic [NUM_HARTS-1:0] err_q;

    assign wd_limit = {1'b0, job_q.countdown} + 30'(TIMEOUT_SLACK);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            cmd_valid_q <= 1'b0;
            job_q       <= '0;
            job_hart_q  <= '0;
            irq_q       <= '0;
`ifdef MVU_WATCHDOG_EN
            wd_cnt_q    <= '0;
            abort_q     <= 1'b0;
            err_q       <= '0;
`endif
        end else begin
            irq_q <= '0;
`ifdef MVU_WATCHDOG_EN
            abort_q <= 1'b0;
            err_q   <= '0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (arb_valid) begin
                        job_q      <= shadow_q[arb_grant];
                        job_hart_q <= arb_grant;
                        rr_ptr_q   <= (arb_grant == LAST_HART) ? '0 : arb_grant + 1'b1;
                        // Zero-length jobs never reach the MVU.
                        if (shadow_q[arb_grant].countdown == '0) begin
                            state_q <= ST_DONE;
                            irq_q   <= grant_mask;
                        end else begin
                            state_q     <= ST_ISSUE;
                            cmd_valid_q <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (mvu_cmd_ready) begin
                        cmd_valid_q <= 1'b0;
                        state_q     <= ST_RUN;
`ifdef MVU_WATCHDOG_EN
                        wd_cnt_q    <= '0;
`endif
                    end
                end
                ST_RUN: begin
                    if (mvu_done) begin
                        state_q <= ST_DONE;
                        irq_q   <= owner_mask;
                    end
`ifdef MVU_WATCHDOG_EN
                    // abort_q is raised in the cycle the count reaches the
                    // limit; the job is then closed with an error one cycle
                    // later unless mvu_done arrives in that same cycle.
                    else if (abort_q) begin
                        state_q <= ST_DONE;
                        irq_q   <= owner_mask;
                        err_q   <= owner_mask;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + 30'd1;
                        if ((wd_cnt_q + 30'd1) == wd_limit) begin
                            abort_q <= 1'b1;
                        end
                    end
`endif
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mvu_cmd_valid = cmd_valid_q;
    assign mvu_job       = job_q;
    assign mvu_job_hart  = job_hart_q;
    assign mvu_irq       = irq_q;
    assign busy          = (state_q != ST_IDLE);

`ifdef MVU_WATCHDOG_EN
    assign mvu_abort = abort_q;
    assign mvu_err   = err_q;
`else
    assign mvu_abort = 1'b0;
    assign mvu_err   = '0;

    logic unused_slack;
    assign unused_slack = (TIMEOUT_SLACK != 0);
`endif

endmodule

// File: tb/tb_mvu_job_dispatcher.sv
// ---------------------------------------------------------------------------
// tb_mvu_job_dispatcher
// Directed bench for mvu_job_dispatcher. Inputs change and outputs are read
// at the falling edge; one tick is one clock cycle. The watchdog scenario is
// compiled in only when MVU_WATCHDOG_EN is defined.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mvu_job_dispatcher;
    import pito_pkg::*;

    localparam int NH = 8;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic [NH-1:0]             mvu_start = '0;
    logic [2*NH-1:0]           csr_mul_mode = '0;
    logic [29*NH-1:0]          csr_countdown = '0;
    logic [6*NH-1:0]           csr_wprec = '0;
    logic [6*NH-1:0]           csr_iprec = '0;
    logic [6*NH-1:0]           csr_oprec = '0;
    logic [9*NH-1:0]           csr_wbase = '0;
    logic [15*NH-1:0]          csr_ibase = '0;
    logic [15*NH-1:0]          csr_obase = '0;
    logic                      mvu_cmd_valid;
    logic                      mvu_cmd_ready = 1'b0;
    mvu_job_t                  mvu_job;
    logic [HART_CNT_WIDTH-1:0] mvu_job_hart;
    logic                      mvu_done = 1'b0;
    logic                      mvu_abort;
    logic [NH-1:0]             mvu_irq;
    logic [NH-1:0]             mvu_err;
    logic                      busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mvu_job_dispatcher #(
        .NUM_HARTS     (NH),
        .TIMEOUT_SLACK (64)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .mvu_start          (mvu_start),
        .csr_mvu_mul_mode   (csr_mul_mode),
        .csr_mvu_countdown  (csr_countdown),
        .csr_mvu_wprecision (csr_wprec),
        .csr_mvu_iprecision (csr_iprec),
        .csr_mvu_oprecision (csr_oprec),
        .csr_mvu_wbaseaddr  (csr_wbase),
        .csr_mvu_ibaseaddr  (csr_ibase),
        .csr_mvu_obaseaddr  (csr_obase),
        .mvu_cmd_valid      (mvu_cmd_valid),
        .mvu_cmd_ready      (mvu_cmd_ready),
        .mvu_job            (mvu_job),
        .mvu_job_hart       (mvu_job_hart),
        .mvu_done           (mvu_done),
        .mvu_abort          (mvu_abort),
        .mvu_irq            (mvu_irq),
        .mvu_err            (mvu_err),
        .busy               (busy)
    );

    task automatic tick;
        @(negedge clk);
    endtask

    function automatic logic [NH-1:0] hart_bit(input int h);
        logic [NH-1:0] v;
        v    = '0;
        v[h] = 1'b1;
        return v;
    endfunction

    task automatic set_csr(input int h, input logic [1:0] mm, input logic [28:0] cd,
                           input logic [5:0] wp, input logic [5:0] ip, input logic [5:0] op,
                           input logic [8:0] wb, input logic [14:0] ib, input logic [14:0] ob);
        csr_mul_mode[h*2 +: 2]   = mm;
        csr_countdown[h*29 +: 29] = cd;
        csr_wprec[h*6 +: 6]      = wp;
        csr_iprec[h*6 +: 6]      = ip;
        csr_oprec[h*6 +: 6]      = op;
        csr_wbase[h*9 +: 9]      = wb;
        csr_ibase[h*15 +: 15]    = ib;
        csr_obase[h*15 +: 15]    = ob;
    endtask

    // ---------------------------------------------------------------- reset
    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) tick;
        checks++;
        if (mvu_cmd_valid !== 1'b0) begin failures++; $display("FAIL reset_cmd_valid got=%b exp=0", mvu_cmd_valid); end
        checks++;
        if (mvu_job !== '0) begin failures++; $display("FAIL reset_job got=%h exp=0", mvu_job); end
        checks++;
        if (mvu_job_hart !== '0) begin failures++; $display("FAIL reset_job_hart got=%0d exp=0", mvu_job_hart); end
        checks++;
        if (mvu_irq !== '0 || mvu_err !== '0 || mvu_abort !== 1'b0) begin
            failures++; $display("FAIL reset_pulses got irq=%h err=%h abort=%b exp=0", mvu_irq, mvu_err, mvu_abort);
        end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst_n = 1'b1;
        repeat (2) tick;
        checks++;
        if (busy !== 1'b0 || mvu_cmd_valid !== 1'b0) begin
            failures++; $display("FAIL post_reset_idle got busy=%b valid=%b exp=0/0", busy, mvu_cmd_valid);
        end
    endtask

    // ---------------------------------------------- round-robin ordering
    task automatic test_rr_order;
        int exp_h [4] = '{1, 5, 6, 1};
        int cyc;
        for (int h = 0; h < NH; h++) begin
            set_csr(h, 2'd1, 29'd5, 6'd2, 6'd2, 6'd2, 9'(h), 15'(h), 15'(h));
        end
        mvu_cmd_ready = 1'b1;
        mvu_start = 8'b0110_0010;
        tick;
        mvu_start = '0;
        for (int j = 0; j < 4; j++) begin
            cyc = 0;
            while (mvu_cmd_valid !== 1'b1 && cyc < 20) begin tick; cyc++; end
            checks++;
            if (mvu_cmd_valid !== 1'b1 || mvu_job_hart !== HART_CNT_WIDTH'(exp_h[j])) begin
                failures++;
                $display("FAIL rr_grant[%0d] got valid=%b hart=%0d exp hart=%0d", j, mvu_cmd_valid, mvu_job_hart, exp_h[j]);
            end
            checks++;
            if (cyc != 1) begin failures++; $display("FAIL rr_grant_latency[%0d] got=%0d exp=1", j, cyc); end
            $display("TXN rr cmd hart=%0d countdown=%0d", mvu_job_hart, mvu_job.countdown);
            tick;
            if (j == 2) begin
                mvu_start = hart_bit(1);
                tick;
                mvu_start = '0;
            end
            mvu_done = 1'b1;
            tick;
            mvu_done = 1'b0;
            checks++;
            if (mvu_irq !== hart_bit(exp_h[j])) begin
                failures++; $display("FAIL rr_irq[%0d] got=%h exp=%h", j, mvu_irq, hart_bit(exp_h[j]));
            end
            tick;
        end
        repeat (3) tick;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL rr_end_idle got busy=%b exp=0", busy); end
    endtask

    // ------------------------------------------------ single job, hart 3
    task automatic test_single;
        int bad;
        set_csr(3, 2'd0, 29'd100, 6'd8, 6'd8, 6'd16, 9'h010, 15'h0100, 15'h0200);
        mvu_cmd_ready = 1'b1;
        mvu_start = hart_bit(3);
        tick;
        mvu_start = '0;
        checks++;
        if (mvu_cmd_valid !== 1'b0) begin failures++; $display("FAIL single_valid_t1 got=%b exp=0", mvu_cmd_valid); end
        tick;
        checks++;
        if (mvu_cmd_valid !== 1'b1 || mvu_job_hart !== 3'd3) begin
            failures++; $display("FAIL single_cmd got valid=%b hart=%0d exp valid=1 hart=3", mvu_cmd_valid, mvu_job_hart);
        end
        checks++;
        if (mvu_job.countdown !== 29'd100 || mvu_job.obase !== 15'h0200) begin
            failures++; $display("FAIL single_job got cd=%0d obase=%h exp cd=100 obase=0200", mvu_job.countdown, mvu_job.obase);
        end
        $display("TXN single cmd hart=%0d countdown=%0d", mvu_job_hart, mvu_job.countdown);
        tick;
        bad = 0;
        for (int k = 0; k < 99; k++) begin
            if (mvu_cmd_valid !== 1'b0 || mvu_irq !== '0 || busy !== 1'b1 || mvu_abort !== 1'b0 || mvu_err !== '0) bad++;
            tick;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL single_run_quiet got bad_cycles=%0d exp=0", bad); end
        mvu_done = 1'b1;
        tick;
        mvu_done = 1'b0;
        checks++;
        if (mvu_irq !== 8'h08) begin failures++; $display("FAIL single_irq got=%h exp=08", mvu_irq); end
        checks++;
        if (mvu_err !== 8'h00) begin failures++; $display("FAIL single_err got=%h exp=00", mvu_err); end
        tick;
        checks++;
        if (mvu_irq !== 8'h00 || busy !== 1'b0) begin
            failures++; $display("FAIL single_irq_one_cycle got irq=%h busy=%b exp 00/0", mvu_irq, busy);
        end
    endtask

    // ------------------------------------- snapshot survives CSR rewrite
    task automatic test_snapshot;
        mvu_job_t exp_job;
        int cyc;
        int bad;
        exp_job = '{mul_mode: 2'd2, countdown: 29'd7, wprec: 6'd3, iprec: 6'd4, oprec: 6'd5,
                    wbase: 9'h1A5, ibase: 15'h1234, obase: 15'h4321};
        mvu_cmd_ready = 1'b0;
        set_csr(0, 2'd1, 29'd5, 6'd1, 6'd1, 6'd1, 9'h001, 15'h0011, 15'h0022);
        set_csr(2, 2'd2, 29'd7, 6'd3, 6'd4, 6'd5, 9'h1A5, 15'h1234, 15'h4321);
        mvu_start = hart_bit(0);
        tick;
        mvu_start = '0;
        tick;
        checks++;
        if (mvu_cmd_valid !== 1'b1 || mvu_job_hart !== 3'd0) begin
            failures++; $display("FAIL snap_first_cmd got valid=%b hart=%0d exp 1/0", mvu_cmd_valid, mvu_job_hart);
        end
        mvu_start = hart_bit(2);
        tick;
        mvu_start = '0;
        set_csr(2, 2'd2, 29'd99, 6'd3, 6'd4, 6'd5, 9'h1A5, 15'h7FFF, 15'h4321);
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            if (mvu_cmd_valid !== 1'b1 || mvu_job_hart !== 3'd0 || mvu_job.ibase !== 15'h0011) bad++;
            tick;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL snap_issue_hold got bad_cycles=%0d exp=0", bad); end
        mvu_cmd_ready = 1'b1;
        tick;
        mvu_done = 1'b1;
        tick;
        mvu_done = 1'b0;
        checks++;
        if (mvu_irq !== 8'h01) begin failures++; $display("FAIL snap_irq0 got=%h exp=01", mvu_irq); end
        cyc = 0;
        while (mvu_cmd_valid !== 1'b1 && cyc < 20) begin tick; cyc++; end
        checks++;
        if (mvu_cmd_valid !== 1'b1 || mvu_job_hart !== 3'd2) begin
            failures++; $display("FAIL snap_second_cmd got valid=%b hart=%0d exp 1/2", mvu_cmd_valid, mvu_job_hart);
        end
        checks++;
        if (mvu_job !== exp_job) begin failures++; $display("FAIL snap_job got=%h exp=%h", mvu_job, exp_job); end
        $display("TXN snapshot cmd hart=%0d ibase=%h", mvu_job_hart, mvu_job.ibase);
        tick;
        mvu_done = 1'b1;
        tick;
        mvu_done = 1'b0;
        checks++;
        if (mvu_irq !== 8'h04) begin failures++; $display("FAIL snap_irq2 got=%h exp=04", mvu_irq); end
        tick;
    endtask

    // ------------------- start while owning RUN is dropped; DONE accepts
    task automatic test_back_to_back;
        int cyc;
        int bad;
        mvu_cmd_ready = 1'b1;
        set_csr(2, 2'd0, 29'd4, 6'd1, 6'd1, 6'd1, 9'h000, 15'h0AAA, 15'h0000);
        mvu_start = hart_bit(2);
        tick;
        mvu_start = '0;
        cyc = 0;
        while (mvu_cmd_valid !== 1'b1 && cyc < 20) begin tick; cyc++; end
        checks++;
        if (mvu_cmd_valid !== 1'b1 || mvu_job.ibase !== 15'h0AAA) begin
            failures++; $display("FAIL b2b_first_cmd got valid=%b ibase=%h exp 1/0AAA", mvu_cmd_valid, mvu_job.ibase);
        end
        $display("TXN b2b cmd hart=%0d ibase=%h", mvu_job_hart, mvu_job.ibase);
        tick;
        mvu_start = hart_bit(2);
        tick;
        mvu_start = '0;
        set_csr(2, 2'd0, 29'd4, 6'd1, 6'd1, 6'd1, 9'h000, 15'h0BBB, 15'h0000);
        tick;
        mvu_done = 1'b1;
        tick;
        mvu_done = 1'b0;
        checks++;
        if (mvu_irq !== 8'h04) begin failures++; $display("FAIL b2b_irq1 got=%h exp=04", mvu_irq); end
        mvu_start = hart_bit(2);
        tick;
        mvu_start = '0;
        checks++;
        if (mvu_irq !== 8'h00) begin failures++; $display("FAIL b2b_irq_single got=%h exp=00", mvu_irq); end
        cyc = 0;
        while (mvu_cmd_valid !== 1'b1 && cyc < 20) begin tick; cyc++; end
        checks++;
        if (mvu_cmd_valid !== 1'b1 || mvu_job_hart !== 3'd2 || mvu_job.ibase !== 15'h0BBB) begin
            failures++;
            $display("FAIL b2b_second_cmd got valid=%b hart=%0d ibase=%h exp 1/2/0BBB", mvu_cmd_valid, mvu_job_hart, mvu_job.ibase);
        end
        $display("TXN b2b cmd hart=%0d ibase=%h", mvu_job_hart, mvu_job.ibase);
        tick;
        mvu_done = 1'b1;
        tick;
        mvu_done = 1'b0;
        checks++;
        if (mvu_irq !== 8'h04) begin failures++; $display("FAIL b2b_irq2 got=%h exp=04", mvu_irq); end
        tick;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            if (mvu_cmd_valid !== 1'b0 || busy !== 1'b0) bad++;
            tick;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL b2b_no_third_job got bad_cycles=%0d exp=0", bad); end
    endtask

    // ------------------------------------------------- zero-length job
    task automatic test_countdown_zero;
        set_csr(4, 2'd0, 29'd0, 6'd1, 6'd1, 6'd1, 9'h000, 15'h0000, 15'h0000);
        mvu_start = hart_bit(4);
        tick;
        mvu_start = '0;
        checks++;
        if (mvu_irq !== 8'h00 || mvu_cmd_valid !== 1'b0) begin
            failures++; $display("FAIL cd0_t1 got irq=%h valid=%b exp 00/0", mvu_irq, mvu_cmd_valid);
        end
        tick;
        checks++;
        if (mvu_irq !== 8'h10 || mvu_cmd_valid !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL cd0_irq got irq=%h valid=%b busy=%b exp 10/0/1", mvu_irq, mvu_cmd_valid, busy);
        end
        $display("TXN cd0 irq=%h", mvu_irq);
        tick;
        checks++;
        if (mvu_irq !== 8'h00 || busy !== 1'b0 || mvu_cmd_valid !== 1'b0) begin
            failures++; $display("FAIL cd0_after got irq=%h busy=%b valid=%b exp 00/0/0", mvu_irq, busy, mvu_cmd_valid);
        end
    endtask

`ifdef MVU_WATCHDOG_EN
    // ------------------------------------------------- watchdog timeout
    task automatic test_watchdog;
        int cyc;
        int bad;
        mvu_cmd_ready = 1'b1;
        set_csr(5, 2'd0, 29'd10, 6'd1, 6'd1, 6'd1, 9'h000, 15'h0000, 15'h0000);
        mvu_start = hart_bit(5);
        tick;
        mvu_start = '0;
        cyc = 0;
        while (mvu_cmd_valid !== 1'b1 && cyc < 20) begin tick; cyc++; end
        tick;
        bad = 0;
        for (int k = 0; k < 74; k++) begin
            if (mvu_abort !== 1'b0 || mvu_irq !== '0) bad++;
            tick;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL wd_early got bad_cycles=%0d exp=0", bad); end
        checks++;
        if (mvu_abort !== 1'b1 || mvu_irq !== 8'h00) begin
            failures++; $display("FAIL wd_abort got abort=%b irq=%h exp 1/00", mvu_abort, mvu_irq);
        end
        tick;
        checks++;
        if (mvu_abort !== 1'b0 || mvu_irq !== 8'h20 || mvu_err !== 8'h20) begin
            failures++; $display("FAIL wd_irq_err got abort=%b irq=%h err=%h exp 0/20/20", mvu_abort, mvu_irq, mvu_err);
        end
        $display("TXN watchdog irq=%h err=%h", mvu_irq, mvu_err);
        tick;
    endtask
`endif

    // ------------------------------------------------ reset during RUN
    task automatic test_reset_midrun;
        int cyc;
        int bad;
        mvu_cmd_ready = 1'b1;
        set_csr(7, 2'd3, 29'd50, 6'd1, 6'd1, 6'd1, 9'h0FF, 15'h0123, 15'h0456);
        set_csr(0, 2'd1, 29'd5, 6'd1, 6'd1, 6'd1, 9'h001, 15'h0011, 15'h0022);
        mvu_start = hart_bit(7);
        tick;
        mvu_start = '0;
        cyc = 0;
        while (mvu_cmd_valid !== 1'b1 && cyc < 20) begin tick; cyc++; end
        $display("TXN midrun cmd hart=%0d", mvu_job_hart);
        tick;
        mvu_start = hart_bit(0);
        tick;
        mvu_start = '0;
        tick;
        rst_n = 1'b0;
        #1;
        checks++;
        if (mvu_cmd_valid !== 1'b0 || mvu_job !== '0 || mvu_job_hart !== '0 || busy !== 1'b0 ||
            mvu_irq !== '0 || mvu_err !== '0 || mvu_abort !== 1'b0) begin
            failures++;
            $display("FAIL midrun_reset_outputs got valid=%b job=%h hart=%0d busy=%b irq=%h exp all 0",
                     mvu_cmd_valid, mvu_job, mvu_job_hart, busy, mvu_irq);
        end
        tick;
        rst_n = 1'b1;
        mvu_done = 1'b1;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            tick;
            mvu_done = 1'b0;
            if (mvu_irq !== '0 || mvu_cmd_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL midrun_no_irq got bad_cycles=%0d exp=0", bad); end
    endtask

    initial begin
        test_reset();
        test_rr_order();
        test_single();
        test_snapshot();
        test_back_to_back();
        test_countdown_zero();
`ifdef MVU_WATCHDOG_EN
        test_watchdog();
`endif
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/mvu_job_dispatcher.md
# mvu_job_dispatcher

Consumes the per-hart MVU configuration and `mvu_start` pulses produced by the barrel CSR bank, and arbitrates the harts' jobs onto the single MVU command port. It returns per-hart `mvu_irq` completion pulses to the CSR bank, closing the CSR-to-MVU loop. It snapshots each hart's job on start, so a hart may rewrite its CSRs while its job waits or runs.

## Interface
- `NUM_HARTS`, 8, number of barrel harts; equals `pito_pkg::NUM_HARTS`.
- `TIMEOUT_SLACK`, 64, extra cycles beyond countdown before watchdog abort (used only with `MVU_WATCHDOG_EN`).
- `clk`  in  1  core clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `mvu_start`  in  NUM_HARTS  per-hart single-cycle start request.
- `csr_mvu_mul_mode`  in  2*NUM_HARTS  hart h at `[h*2 +: 2]`.
- `csr_mvu_countdown`  in  29*NUM_HARTS  job length in MVU cycles.
- `csr_mvu_wprecision`, `csr_mvu_iprecision`, `csr_mvu_oprecision`  in  6*NUM_HARTS each.
- `csr_mvu_wbaseaddr`  in  9*NUM_HARTS.
- `csr_mvu_ibaseaddr`, `csr_mvu_obaseaddr`  in  15*NUM_HARTS each.
- `mvu_cmd_valid`  out  1  job offered to MVU.
- `mvu_cmd_ready`  in  1  MVU accepts job.
- `mvu_job`  out  `mvu_job_t` (88 bits)  registered job fields.
- `mvu_job_hart`  out  HART_CNT_WIDTH  owner of `mvu_job`.
- `mvu_done`  in  1  single-cycle MVU completion.
- `mvu_abort`  out  1  single-cycle abort to MVU.
- `mvu_irq`  out  NUM_HARTS  single-cycle completion pulse per hart.
- `mvu_err`  out  NUM_HARTS  single-cycle error pulse, coincident with `mvu_irq`.
- `busy`  out  1  high in any state except IDLE.

## Operation
- Per hart: `pending[h]` flag plus an 88-bit `mvu_job_t` shadow register.
- Start accepted when `mvu_start[h]` is high and hart h is neither pending nor owning the job in ISSUE or RUN. Acceptance sets `pending[h]` and snapshots hart h's slices. Starts that are not accepted are dropped silently.
- FSM states: IDLE, ISSUE, RUN, DONE.
- IDLE: if any `pending` bit is set, grant round-robin starting from `rr_ptr` and wrapping. On grant: copy the shadow to `mvu_job`, set `mvu_job_hart`, clear `pending[g]`, and set `rr_ptr = g+1` (mod NUM_HARTS). Go to ISSUE, or go straight to DONE if the granted countdown is 0 (no command is issued).
- ISSUE: `mvu_cmd_valid`=1. `mvu_job` and `mvu_job_hart` are held stable. Go to RUN on `mvu_cmd_ready`.
- RUN: wait for `mvu_done`, then go to DONE. `mvu_done` in any other state is ignored.
- DONE: pulse `mvu_irq[mvu_job_hart]` for one cycle, then go to IDLE.
- If a start for the owning hart arrives in the same cycle as DONE, it is accepted.
- Reset values: all outputs 0, `pending`=0, `rr_ptr`=0, state IDLE. Reset asserted mid-job drops the job; no irq is produced.

## Timing
- `mvu_start` at cycle t: pending at t+1. If the FSM is idle, the grant happens at t+1, and `mvu_cmd_valid` is high from t+2.
- `mvu_done` at cycle d: `mvu_irq` high at d+1. The next grant is made at d+2 at the earliest.
- Countdown-0 job, started at t: `mvu_irq` at t+2.
- Throughput: at most one job in flight. Minimum job-to-job gap is 2 idle cycles.

## Configuration
- `MVU_WATCHDOG_EN` defined: in RUN, a 30-bit counter runs from 0 (cleared on RUN entry). When it reaches `countdown + TIMEOUT_SLACK` with no `mvu_done`:
  - pulse `mvu_abort` for one cycle and go to DONE;
  - DONE pulses both `mvu_irq[h]` and `mvu_err[h]`.
  - If `mvu_done` and the timeout coincide, `mvu_done` wins and no error is raised.
- `MVU_WATCHDOG_EN` undefined: no counter, `mvu_abort` and `mvu_err` tied to 0, RUN waits indefinitely.

## Structure
- In `pito_pkg`:
  - `mvu_job_t` packed struct: `mul_mode`, `countdown`, `wprec`, `iprec`, `oprec`, `wbase`, `ibase`, `obase`;
  - `mvu_disp_state_e` enum;
  - `HART_CNT_WIDTH`.
- Sub-module `mvu_rr_arbiter`: combinational round-robin grant. Inputs: request vector and pointer. Outputs: grant index and valid.

## Test plan
- Hart 3 start, countdown=100, `mvu_cmd_ready` tied 1, `mvu_done` 100 cycles after accept → one cmd with `mvu_job_hart`=3 and `mvu_job.countdown`=100; `mvu_irq`=8'h08 for one cycle, one cycle after done.
- Harts 1, 5 and 6 start in the same cycle → grants in order 1, 5, 6. Then a hart 1 start during hart 6's RUN → hart 1 served after 6.
- Hart 2 starts, then rewrites its `csr_mvu_ibaseaddr` to 0x7FFF while pending → issued job keeps the original ibase.
- Second hart 2 start while its job is in RUN → dropped, exactly one irq. A start in the DONE cycle → a second job is issued.
- Countdown 0 → no `mvu_cmd_valid`; `mvu_irq` 2 cycles after start.
- `MVU_WATCHDOG_EN`, countdown=10, no done → `mvu_abort` 74 cycles after RUN entry; `mvu_irq` and `mvu_err` on the same hart the next cycle. Also assert `rst_n` low mid-RUN → all outputs 0 and no irq.
